// File: rtl/change_dispenser_if.sv
// rtl/change_dispenser_if.sv - request/coin-drive bundle between dispenser and change payer
interface change_dispenser_if #(
    parameter int AMT_W = 6
);
    logic             REQ;
    logic [AMT_W-1:0] AMT;
    logic [2:0]       EMPTY;
    logic             ACK;
    logic             BUSY;
    logic [2:0]       COUT;
    logic             DONE;
    logic             FAULT;
    logic [AMT_W-1:0] REM;

    modport master (
        output REQ, AMT, EMPTY,
        input  ACK, BUSY, COUT, DONE, FAULT, REM
    );

    modport slave (
        input  REQ, AMT, EMPTY,
        output ACK, BUSY, COUT, DONE, FAULT, REM
    );
endinterface

// File: rtl/change_dispenser.sv
// rtl/change_dispenser.sv - greedy coin change payer driving three coin-tube solenoids
module change_dispenser #(
    parameter int PULSE_CYC = 4,
    parameter int GAP_CYC   = 2,
    parameter int AMT_W     = 6
) (
    input  logic              CLK,
    input  logic              RESET,
    change_dispenser_if.slave bus
);
    localparam int CNT_MAX = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SELECT, S_EJECT, S_GAP, S_FINISH
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [AMT_W-1:0] r_q, r_d;
    logic [AMT_W-1:0] rem_q, rem_d;
    logic [2:0]       cout_q, cout_d;
    logic             ack_q, ack_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             fault_q, fault_d;
    logic [2:0]       pick;
    logic [AMT_W-1:0] coin_val;

    // Greedy choice: largest denomination that fits in R and whose tube is not empty
    always_comb begin
        pick = 3'b000;
        if (r_q >= AMT_W'(5) && !bus.EMPTY[2]) begin
            pick = 3'b100;
        end else if (r_q >= AMT_W'(2) && !bus.EMPTY[1]) begin
            pick = 3'b010;
        end else if (r_q >= AMT_W'(1) && !bus.EMPTY[0]) begin
            pick = 3'b001;
        end
    end

    always_comb begin
        case (cout_q)
            3'b100:  coin_val = AMT_W'(5);
            3'b010:  coin_val = AMT_W'(2);
            3'b001:  coin_val = AMT_W'(1);
            default: coin_val = '0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            r_q     <= '0;
            rem_q   <= '0;
            cout_q  <= 3'b000;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            rem_q   <= rem_d;
            cout_q  <= cout_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            fault_q <= fault_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.REQ) state_d = S_SELECT;
            end
            S_SELECT: begin
                if (pick != 3'b000) begin
                    state_d = S_EJECT;
                    cnt_d   = CNT_W'(PULSE_CYC - 1);
                end else begin
                    state_d = S_FINISH;
                end
            end
            S_EJECT: begin
                if (cnt_q == '0) begin
                    state_d = S_GAP;
                    cnt_d   = CNT_W'(GAP_CYC - 1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_GAP: begin
                if (cnt_q == '0) state_d = S_SELECT;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Registered outputs are computed one cycle ahead from the transition being taken
    always_comb begin
        r_d     = r_q;
        rem_d   = rem_q;
        cout_d  = cout_q;
        fault_d = fault_q;
        ack_d   = 1'b0;
        done_d  = 1'b0;
        busy_d  = (state_d != S_IDLE);
        case (state_q)
            S_IDLE: begin
                if (bus.REQ) begin
                    r_d     = bus.AMT;
                    rem_d   = bus.AMT;
                    fault_d = 1'b0;
                    ack_d   = 1'b1;
                end
            end
            S_SELECT: begin
                if (pick != 3'b000) begin
                    cout_d = pick;
                end else begin
                    rem_d   = r_q;
                    fault_d = (r_q != '0);
                    done_d  = 1'b1;
                end
            end
            S_EJECT: begin
                if (cnt_q == '0) begin
                    r_d    = r_q - coin_val;
                    cout_d = 3'b000;
                end
            end
            default: ;
        endcase
    end

    assign bus.ACK   = ack_q;
    assign bus.BUSY  = busy_q;
    assign bus.COUT  = cout_q;
    assign bus.DONE  = done_q;
    assign bus.FAULT = fault_q;
    assign bus.REM   = rem_q;
endmodule

// File: tb/tb_change_dispenser.sv
// tb/tb_change_dispenser.sv - directed vector bench for change_dispenser
module tb_change_dispenser;
    localparam int PULSE = 4;
    localparam int GAP   = 2;

    typedef struct {
        logic [5:0]  amt;
        logic [2:0]  e0;
        logic [2:0]  e1;
        int          ncoin;
        logic [23:0] coins;
        int          done_cyc;
        logic [5:0]  rem;
        logic        fault;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    change_dispenser_if #(.AMT_W(6)) bus ();

    change_dispenser #(.PULSE_CYC(PULSE), .GAP_CYC(GAP), .AMT_W(6)) dut (
        .CLK   (clk),
        .RESET (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [5:0] amt, input logic [2:0] e0, input logic [2:0] e1,
                                input int ncoin, input logic [23:0] coins, input int done_cyc,
                                input logic [5:0] rem, input logic fault);
        vec_t v;
        v.amt = amt; v.e0 = e0; v.e1 = e1; v.ncoin = ncoin; v.coins = coins;
        v.done_cyc = done_cyc; v.rem = rem; v.fault = fault;
        return v;
    endfunction

    // Cycle k below is the clock period following the (k-1)th edge after acceptance
    task automatic run_vec(input vec_t v, input int poke, input string tag);
        int          acks;
        int          done_at;
        int          run_len;
        logic [2:0]  prev;
        logic [2:0]  got[$];
        int          starts[$];
        logic [2:0]  exp_c;
        @(negedge clk);
        bus.REQ = 1'b1; bus.AMT = v.amt; bus.EMPTY = v.e0;
        @(posedge clk);
        acks = 0; done_at = -1; run_len = 0; prev = 3'b000;
        for (int cyc = 1; cyc <= 200 && done_at < 0; cyc++) begin
            @(negedge clk);
            if (cyc == 1) bus.REQ = 1'b0;
            if (cyc == 6) bus.EMPTY = v.e1;
            if (cyc == poke) begin
                bus.REQ = 1'b1; bus.AMT = 6'd50;
            end else if (cyc == poke + 1) begin
                bus.REQ = 1'b0;
            end
            if (bus.ACK) acks++;
            if (cyc == 1) begin
                chk({tag, " ack_c1"}, int'(bus.ACK), 1);
                chk({tag, " busy_c1"}, int'(bus.BUSY), 1);
                chk({tag, " rem_load"}, int'(bus.REM), int'(v.amt));
                chk({tag, " fault_clr"}, int'(bus.FAULT), 0);
            end
            if (bus.COUT != 3'b000 && prev == 3'b000) begin
                got.push_back(bus.COUT);
                starts.push_back(cyc);
                run_len = 1;
            end else if (bus.COUT != 3'b000) begin
                run_len++;
                if (bus.COUT != prev) chk({tag, " cout_stable"}, int'(bus.COUT), int'(prev));
            end else if (prev != 3'b000) begin
                chk({tag, " pulse_len"}, run_len, PULSE);
            end
            if (bus.DONE) done_at = cyc;
            prev = bus.COUT;
        end
        bus.REQ = 1'b0;
        chk({tag, " done_cyc"}, done_at, v.done_cyc);
        chk({tag, " ack_count"}, acks, 1);
        chk({tag, " ncoin"}, got.size(), v.ncoin);
        for (int i = 0; i < v.ncoin && i < got.size(); i++) begin
            exp_c = v.coins[23 - 3*i -: 3];
            chk($sformatf("%s coin%0d", tag, i), int'(got[i]), int'(exp_c));
            chk($sformatf("%s start%0d", tag, i), starts[i], 2 + i * (1 + PULSE + GAP));
        end
        chk({tag, " cout_at_done"}, int'(bus.COUT), 0);
        chk({tag, " rem"}, int'(bus.REM), int'(v.rem));
        chk({tag, " fault"}, int'(bus.FAULT), int'(v.fault));
        @(negedge clk);
        chk({tag, " done_pulse"}, int'(bus.DONE), 0);
        chk({tag, " busy_end"}, int'(bus.BUSY), 0);
        repeat (2) @(negedge clk);
        chk({tag, " rem_hold"}, int'(bus.REM), int'(v.rem));
        chk({tag, " fault_hold"}, int'(bus.FAULT), int'(v.fault));
    endtask

    vec_t vecs[$];

    initial begin
        bus.REQ = 1'b0; bus.AMT = '0; bus.EMPTY = 3'b000;

        vecs.push_back(mk(6'd8,  3'b000, 3'b000, 3, {3'b100, 3'b010, 3'b001, 15'b0}, 23, 6'd0, 1'b0));
        vecs.push_back(mk(6'd7,  3'b100, 3'b100, 4, {3'b010, 3'b010, 3'b010, 3'b001, 12'b0}, 30, 6'd0, 1'b0));
        vecs.push_back(mk(6'd6,  3'b001, 3'b001, 1, {3'b100, 21'b0}, 9, 6'd1, 1'b1));
        vecs.push_back(mk(6'd0,  3'b000, 3'b000, 0, 24'b0, 2, 6'd0, 1'b0));
        vecs.push_back(mk(6'd4,  3'b000, 3'b010, 3, {3'b010, 3'b001, 3'b001, 15'b0}, 23, 6'd0, 1'b0));
        vecs.push_back(mk(6'd11, 3'b000, 3'b000, 3, {3'b100, 3'b100, 3'b001, 15'b0}, 23, 6'd0, 1'b0));
        vecs.push_back(mk(6'd9,  3'b111, 3'b111, 0, 24'b0, 2, 6'd9, 1'b1));
        vecs.push_back(mk(6'd13, 3'b010, 3'b010, 5, {3'b100, 3'b100, 3'b001, 3'b001, 3'b001, 9'b0}, 37, 6'd0, 1'b0));

        repeat (3) @(negedge clk);
        chk("reset_ack", int'(bus.ACK), 0);
        chk("reset_busy", int'(bus.BUSY), 0);
        chk("reset_cout", int'(bus.COUT), 0);
        chk("reset_done", int'(bus.DONE), 0);
        chk("reset_fault", int'(bus.FAULT), 0);
        chk("reset_rem", int'(bus.REM), 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(vecs[i], -10, $sformatf("vec%0d", i));
        end

        // REQ pulsed mid-payment must be ignored
        run_vec(mk(6'd3, 3'b000, 3'b000, 2, {3'b010, 3'b001, 18'b0}, 16, 6'd0, 1'b0), 5, "busy_req");

        // Reset asserted in the third EJECT cycle abandons the payment
        @(negedge clk);
        bus.REQ = 1'b1; bus.AMT = 6'd5; bus.EMPTY = 3'b000;
        @(posedge clk);
        @(negedge clk);
        bus.REQ = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_pre_cout", int'(bus.COUT), 4);
        chk("rst_pre_busy", int'(bus.BUSY), 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_cout", int'(bus.COUT), 0);
        chk("rst_busy", int'(bus.BUSY), 0);
        chk("rst_rem", int'(bus.REM), 0);
        chk("rst_fault", int'(bus.FAULT), 0);
        chk("rst_done", int'(bus.DONE), 0);
        chk("rst_ack", int'(bus.ACK), 0);
        rst_n = 1'b1;
        @(negedge clk);
        run_vec(mk(6'd2, 3'b000, 3'b000, 1, {3'b010, 21'b0}, 9, 6'd0, 1'b0), -10, "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/change_dispenser.md
# change_dispenser

Coin change-return controller for the vending machine. It is the paying-out counterpart of the dispenser FSM's coin-input side. The dispenser issues a change request with an amount in credit units; this block ejects coins one at a time through three coin-tube solenoids, largest denomination first, skipping empty tubes. It then reports completion and any unpaid remainder. Coin codes on `COUT` use the same one-hot encoding the dispenser accepts on `CIN`.

## Interface
- `PULSE_CYC`, default 4: cycles a solenoid is held on per coin (≥1).
- `GAP_CYC`, default 2: cycles with all solenoids off between coins (≥1).
- `AMT_W`, default 6: width of amount/remainder in credit units.

Ports:
- `CLK` in 1: single clock; all logic on its rising edge.
- `RESET` in 1: synchronous, active-low reset.
- `REQ` in 1: change request from the dispenser. Sampled only in IDLE.
- `AMT` in AMT_W: change amount, latched on the edge that accepts `REQ`.
- `EMPTY` in 3: tube-empty sensors. Bit 2 is the 5-unit tube, bit 1 the 2-unit tube, bit 0 the 1-unit tube. 1 means empty.
- `ACK` out 1: one-cycle pulse confirming request acceptance.
- `BUSY` out 1: high from acceptance until FINISH completes.
- `COUT` out 3: one-hot solenoid drive. 100 ejects a 5-unit coin, 010 a 2-unit coin, 001 a 1-unit coin, 000 means off.
- `DONE` out 1: one-cycle completion pulse.
- `FAULT` out 1: change could not be paid in full.
- `REM` out AMT_W: unpaid remainder.

## Operation
- States: IDLE, SELECT, EJECT, GAP, FINISH.
- **IDLE**
  - `REQ`=1 → latch `AMT` into the remaining register `R`, clear `FAULT`, go to SELECT, assert `ACK` and `BUSY`.
  - `REQ`=0 → stay in IDLE.
- **SELECT** (one cycle). Samples `EMPTY` and picks the greedy coin:
  - `R`≥5 and `!EMPTY[2]` → 5-unit coin.
  - else `R`≥2 and `!EMPTY[1]` → 2-unit coin.
  - else `R`≥1 and `!EMPTY[0]` → 1-unit coin.
  - A coin is chosen → go to EJECT with `COUT` set to that coin.
  - `R`=0 → go to FINISH with `FAULT`=0.
  - `R`>0 and no coin eligible → go to FINISH with `FAULT`=1.
- **EJECT**: `COUT` is held constant for exactly `PULSE_CYC` cycles. On the edge leaving EJECT, `R` ← `R` − coin value and `COUT` ← 000, then go to GAP.
- **GAP**: `COUT`=000 for exactly `GAP_CYC` cycles, then go to SELECT.
- **FINISH** (one cycle): `DONE`=1, `REM`=`R`. Next edge → IDLE with `BUSY`=0.
- **Arithmetic**: subtraction never underflows, because a coin is chosen only if its value ≤ `R`.
- **Outputs in IDLE**:
  - `REM` and `FAULT` keep their last FINISH values until the next accepted `REQ`.
  - At acceptance, `REM` is loaded with `AMT` and `FAULT` is cleared.
- **Boundary conditions**:
  - `REQ` while `BUSY`: ignored; no second `ACK`; the latched amount is unaffected.
  - `AMT`=0: SELECT → FINISH. `DONE` is produced, no coin is ejected, `FAULT`=0.
  - `EMPTY` changing during EJECT/GAP: no effect until the next SELECT.
  - A tube empties mid-payment: the next SELECT falls back to a smaller denomination, or faults.
  - `RESET`=0 at any point, including mid-EJECT: on that edge go to IDLE and clear all outputs. The solenoid pulse is truncated and the payment abandoned.

## Timing
- All outputs are registered.
- Reset values: `ACK`=0, `BUSY`=0, `COUT`=000, `DONE`=0, `FAULT`=0, `REM`=0, state IDLE, `R`=0.
- Cycle numbering: cycle 0 is the edge that accepts `REQ`. `ACK`/`BUSY` are high in cycle 1, which is the SELECT cycle.
- Cost per coin: 1 (SELECT) + `PULSE_CYC` + `GAP_CYC` cycles.
- `DONE` latency after acceptance: N coins → `DONE` high in cycle 1 + N·(1+`PULSE_CYC`+`GAP_CYC`) + 1.
  - `AMT`=0 → cycle 2.
- Earliest next acceptance: the cycle after FINISH, when `BUSY`=0.

## Test plan
- Defaults, `EMPTY`=000, `AMT`=8:
  - `COUT` goes 100 (cycles 2–5), 010 (cycles 9–12), 001 (cycles 16–19).
  - `DONE` in cycle 23 with `REM`=0, `FAULT`=0.
- `AMT`=7, `EMPTY`=100:
  - Coins are 010, 010, 010, 001.
  - `DONE` with `REM`=0, `FAULT`=0.
- `AMT`=6, `EMPTY`=001:
  - One 100 coin, then FINISH with `FAULT`=1, `REM`=1.
  - `FAULT`/`REM` hold in IDLE until the next `REQ`.
- `AMT`=0:
  - `ACK` in cycle 1, `DONE` in cycle 2, `COUT` never nonzero.
  - Then `REQ` pulsed during a later 3-unit payment: ignored, no extra `ACK`, payment of 3 completes unchanged.
- `AMT`=5, `RESET` driven low in the 3rd EJECT cycle:
  - Next edge: `COUT`=000 and all outputs at reset values.
  - After release, a new `REQ` with `AMT`=2 pays one 010 coin normally.
